// File: rtl/mha_pkg.sv
// Shared definitions for the attention datapath: lane format, Q2.13 fields and
// the output-collector state encoding.
package mha_pkg;

  localparam int unsigned MHA_DW      = 16;
  localparam int unsigned Q_SIGN_BITS = 1;
  localparam int unsigned Q_INT_BITS  = 2;
  localparam int unsigned Q_FRAC_BITS = 13;

  typedef logic [MHA_DW-1:0] lane_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2
  } col_state_e;

  // Bit offset of lane `lane` inside a flat bus of `width`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sa_skew_ring.sv
// Ring of result rows: one independent write port per lane (own row slot),
// one combinational whole-row read port.
module sa_skew_ring
  import mha_pkg::*;
#(
  parameter int unsigned N_COL = 64,
  parameter int unsigned DW    = MHA_DW,
  parameter int unsigned RING  = 64,
  parameter int unsigned AW    = $clog2(RING)
) (
  input  logic                i_clk,
  input  logic [N_COL-1:0]    i_we,
  input  logic [N_COL*AW-1:0] i_wr_idx,
  input  logic [N_COL*DW-1:0] i_wr_data,
  input  logic [AW-1:0]       i_rd_idx,
  output logic [N_COL*DW-1:0] o_rd_data
);

  for (genvar g = 0; g < N_COL; g++) begin : g_lane
    logic [DW-1:0] r_mem [RING];

    always_ff @(posedge i_clk) begin
      if (i_we[g]) begin
        r_mem[i_wr_idx[g*AW +: AW]] <= i_wr_data[g*DW +: DW];
      end
    end

    assign o_rd_data[g*DW +: DW] = r_mem[i_rd_idx];
  end

endmodule

// File: rtl/sa_out_collector.sv
// Deskews the systolic array bottom-row outputs into whole rows and streams
// them out in order over valid/ready, one tile per I_START.
module sa_out_collector
  import mha_pkg::*;
#(
  parameter int unsigned N_COL = 64,
  parameter int unsigned DW    = MHA_DW,
  parameter int unsigned ROWS  = 64,
  parameter int unsigned RING  = 64
) (
  input  logic                    I_CLK,
  input  logic                    I_RST,
  input  logic                    I_START,
  input  logic                    I_SHIFT,
  input  logic [N_COL*DW-1:0]     I_D,
  output logic                    O_VLD,
  input  logic                    I_RDY,
  output logic [N_COL*DW-1:0]     O_DATA,
  output logic [$clog2(ROWS)-1:0] O_ROW,
  output logic                    O_BUSY,
  output logic                    O_DONE,
  output logic                    O_OVF
);

  localparam int unsigned KW     = $clog2(ROWS + N_COL);
  localparam int unsigned PW     = $clog2(ROWS + 1);
  localparam int unsigned AW     = $clog2(RING);
  localparam int unsigned OW     = $clog2(ROWS);
  localparam int unsigned K_LAST = ROWS + N_COL - 2;

  col_state_e          r_state, w_state_nxt;
  logic [KW-1:0]       r_k;
  logic [PW-1:0]       r_p, r_cnt;
  logic                r_vld, r_done, r_ovf;
  logic [N_COL*DW-1:0] r_data;
  logic [OW-1:0]       r_row;

  logic                w_strobe, w_complete, w_pop, w_load;
  int                  w_lrow [N_COL];
  int                  w_rd_p, w_avail;
  logic [N_COL-1:0]    w_we, w_ovf_lane;
  logic [N_COL*AW-1:0] w_wr_idx;
  logic [AW-1:0]       w_rd_idx;
  logic [N_COL*DW-1:0] w_rd_data, w_row_data;

  assign w_strobe   = (r_state == StCollect) && I_SHIFT;
  // Strobe k completes row k-(N_COL-1), the moment the last lane lands.
  assign w_complete = w_strobe && (int'(r_k) >= int'(N_COL) - 1) &&
                      (int'(r_k) < int'(N_COL) - 1 + int'(ROWS));
  assign w_pop      = r_vld && I_RDY;
  assign w_rd_p     = int'(r_p) + (w_pop ? 1 : 0);
  assign w_avail    = int'(r_cnt) + (w_complete ? 1 : 0);
  assign w_load     = (r_state != StIdle) && (!r_vld || w_pop) && (w_avail > w_rd_p);
  assign w_rd_idx   = AW'(w_rd_p);

  // Lane i on strobe k carries row k-i; rows still owned by an unpopped slot are dropped.
  always_comb begin
    w_we       = '0;
    w_ovf_lane = '0;
    w_wr_idx   = '0;
    for (int i = 0; i < int'(N_COL); i++) begin
      w_lrow[i] = int'(r_k) - i;
      if (w_strobe && (w_lrow[i] >= 0) && (w_lrow[i] < int'(ROWS))) begin
        if (w_lrow[i] >= int'(r_p) + int'(RING)) begin
          w_ovf_lane[i] = 1'b1;
        end else begin
          w_we[i] = 1'b1;
        end
      end
      w_wr_idx[i*AW +: AW] = AW'(w_lrow[i]);
    end
  end

  // Bypass lanes landing in the row being loaded this very cycle.
  always_comb begin
    w_row_data = w_rd_data;
    for (int i = 0; i < int'(N_COL); i++) begin
      if (w_we[i] && (w_lrow[i] == w_rd_p)) begin
        w_row_data[lane_lsb(i, DW) +: DW] = I_D[lane_lsb(i, DW) +: DW];
      end
    end
  end

  sa_skew_ring #(
    .N_COL (N_COL),
    .DW    (DW),
    .RING  (RING),
    .AW    (AW)
  ) u_ring (
    .i_clk     (I_CLK),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (I_D),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (I_START) w_state_nxt = StCollect;
      StCollect: if (w_strobe && (r_k == KW'(K_LAST))) w_state_nxt = StDrain;
      StDrain:   if (w_pop && (r_p == PW'(ROWS - 1))) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == StDrain) && w_pop && (r_p == PW'(ROWS - 1));
      if ((r_state == StIdle) && I_START) begin
        r_k   <= '0;
        r_p   <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_strobe) r_k <= r_k + KW'(1);
        if (w_pop)    r_p <= r_p + PW'(1);
        r_cnt <= PW'(w_avail);
        if (|w_ovf_lane) r_ovf <= 1'b1;
      end
      if (w_load) begin
        r_vld  <= 1'b1;
        r_data <= w_row_data;
        r_row  <= OW'(w_rd_p);
      end else if (w_pop) begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign O_VLD  = r_vld;
  assign O_DATA = r_data;
  assign O_ROW  = r_row;
  assign O_BUSY = (r_state != StIdle);
  assign O_DONE = r_done;
  assign O_OVF  = r_ovf;

endmodule

// File: tb/tb_sa_out_collector.sv
// Bench for sa_out_collector: a 3-row and an 8-row instance on shared stimulus,
// a row-level scoreboard, constant row tables and hand-written corner sequences.
module tb_sa_out_collector;

  localparam int NC = 4;
  localparam int LW = 16;
  localparam int RG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, start = 1'b0, shift = 1'b0, rdy = 1'b0;
  logic [NC*LW-1:0] d = '0;

  logic             a_vld, a_busy, a_done, a_ovf;
  logic [NC*LW-1:0] a_data;
  logic [1:0]       a_row;
  logic             b_vld, b_busy, b_done, b_ovf;
  logic [NC*LW-1:0] b_data;
  logic [2:0]       b_row;

  sa_out_collector #(.N_COL(NC), .DW(LW), .ROWS(3), .RING(RG)) dut_a (
    .I_CLK(clk), .I_RST(rst), .I_START(start), .I_SHIFT(shift), .I_D(d),
    .O_VLD(a_vld), .I_RDY(rdy), .O_DATA(a_data), .O_ROW(a_row),
    .O_BUSY(a_busy), .O_DONE(a_done), .O_OVF(a_ovf)
  );

  sa_out_collector #(.N_COL(NC), .DW(LW), .ROWS(8), .RING(RG)) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_START(start), .I_SHIFT(shift), .I_D(d),
    .O_VLD(b_vld), .I_RDY(rdy), .O_DATA(b_data), .O_ROW(b_row),
    .O_BUSY(b_busy), .O_DONE(b_done), .O_OVF(b_ovf)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected lane values per row, filled from the skew rule row = k - lane.
  logic [15:0] m_row [8][NC];
  bit          m_ok  [8][NC];
  logic [63:0] m_got [8];
  int          m_k, m_pops, m_rows, m_done_cnt, m_prev_row, m_seen, tile_id;
  bit          m_sel_b, m_ovf, m_hold, mon_en, rnd_rdy;
  logic [63:0] m_prev_data;

  typedef struct {
    int          row;
    logic [63:0] data;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = ($urandom_range(0, 99) < 60);
  endtask

  task automatic reset_all();
    mon_en = 1'b0;
    rst    = 1'b1;
    start  = 1'b0;
    shift  = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_tile(input bit sel_b, input int rows);
    m_sel_b = sel_b;
    m_rows  = rows;
    tile_id++;
    mon_en  = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic strobe(input bit rnd, input int gap);
    for (int i = 0; i < NC; i++) begin
      d[i*LW +: LW] = rnd ? 16'($urandom) : 16'((m_k - i) * 16 + i);
    end
    shift = 1'b1;
    tick();
    shift = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (m_done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(m_done_cnt > 0), 64'd1);
    repeat (3) tick();
    chk({tag, "_done_once"}, 64'(m_done_cnt), 64'd1);
    chk({tag, "_rows"}, 64'(m_pops), 64'(m_rows));
    chk({tag, "_ovf"}, 64'(m_sel_b ? b_ovf : a_ovf), 64'(m_ovf));
    chk({tag, "_idle"}, 64'(m_sel_b ? b_busy : a_busy), 64'd0);
  endtask

  always @(negedge clk) begin
    logic        vld, dn;
    logic [63:0] od, ed, em;
    int          orow, r;
    if (tile_id != m_seen) begin
      m_seen = tile_id;
      m_k = 0; m_pops = 0; m_done_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
      for (int j = 0; j < 8; j++) for (int i = 0; i < NC; i++) m_ok[j][i] = 1'b0;
    end
    if (mon_en) begin
      vld  = m_sel_b ? b_vld : a_vld;
      od   = m_sel_b ? b_data : a_data;
      orow = m_sel_b ? int'(b_row) : int'(a_row);
      dn   = m_sel_b ? b_done : a_done;
      if (m_hold) begin
        chk("hold_vld", 64'(vld), 64'd1);
        chk("hold_data", od, m_prev_data);
        chk("hold_row", 64'(orow), 64'(m_prev_row));
      end
      if (shift) begin
        for (int i = 0; i < NC; i++) begin
          r = m_k - i;
          if (r >= 0 && r < m_rows) begin
            if (r >= m_pops + RG) begin
              m_ovf = 1'b1;
              m_ok[r][i] = 1'b0;
            end else begin
              m_row[r][i] = d[i*LW +: LW];
              m_ok[r][i]  = 1'b1;
            end
          end
        end
        m_k++;
      end
      if (vld && rdy) begin
        if (m_pops < m_rows) begin
          ed = '0;
          em = '0;
          for (int i = 0; i < NC; i++) begin
            if (m_ok[m_pops][i]) begin
              ed[i*LW +: LW] = m_row[m_pops][i];
              em[i*LW +: LW] = 16'hffff;
            end
          end
          chk("pop_row", 64'(orow), 64'(m_pops));
          chk("pop_data", od & em, ed);
          m_got[m_pops] = od;
        end else begin
          chk("extra_pop", 64'(m_pops), 64'(m_rows - 1));
        end
        m_pops++;
      end
      m_hold      = vld && !rdy;
      m_prev_data = od;
      m_prev_row  = orow;
      if (dn) m_done_cnt++;
    end
  end

  initial begin
    tbl[0] = '{0, 64'h0003_0002_0001_0000};
    tbl[1] = '{1, 64'h0013_0012_0011_0010};
    tbl[2] = '{2, 64'h0023_0022_0021_0020};

    // Reset with random inputs
    rst = 1'b1;
    repeat (2) begin
      start = 1'($urandom); shift = 1'($urandom); rdy = 1'($urandom);
      d = {$urandom, $urandom};
      tick();
    end
    chk("rst_vld", 64'({a_vld, b_vld}), 64'd0);
    chk("rst_data", a_data | b_data, 64'd0);
    chk("rst_row", 64'({a_row, b_row}), 64'd0);
    chk("rst_busy", 64'({a_busy, b_busy}), 64'd0);
    chk("rst_done_ovf", 64'({a_done, b_done, a_ovf, b_ovf}), 64'd0);
    start = 1'b0; shift = 1'b0; rdy = 1'b0; d = '0;
    reset_all();

    // Nominal tile, ready high
    rdy = 1'b1;
    start_tile(0, 3);
    for (int s = 0; s < 6; s++) begin
      strobe(0, 1);
      if (s == 2) chk("nom_vld_early", 64'(a_vld), 64'd0);
      if (s == 3) begin
        chk("nom_vld_rise", 64'(a_vld), 64'd1);
        chk("nom_first_row", 64'(a_row), 64'd0);
        chk("nom_first_data", a_data, tbl[0].data);
      end
      repeat (4) tick();
    end
    wait_done("nom");
    for (int r = 0; r < 3; r++) chk("nom_tbl", m_got[r], tbl[r].data);

    // Backpressure until after the last strobe
    rdy = 1'b0;
    start_tile(0, 3);
    for (int s = 0; s < 6; s++) begin
      strobe(0, 5);
      if (s >= 3) begin
        chk("bp_vld", 64'(a_vld), 64'd1);
        chk("bp_row", 64'(a_row), 64'(tbl[0].row));
        chk("bp_data", a_data, tbl[0].data);
      end
    end
    rdy = 1'b1;
    wait_done("bp");
    for (int r = 0; r < 3; r++) chk("bp_tbl", m_got[r], tbl[r].data);

    // Overflow on the 8-row instance
    reset_all();
    rdy = 1'b0;
    start_tile(1, 8);
    for (int s = 0; s < 11; s++) begin
      strobe(0, 1);
      if (s == 3) chk("ovf_before", 64'(b_ovf), 64'd0);
      if (s == 4) chk("ovf_set", 64'(b_ovf), 64'd1);
      repeat (4) tick();
    end
    chk("ovf_row0_intact", b_data, tbl[0].data);
    rdy = 1'b1;
    wait_done("ovf");
    chk("ovf_sticky", 64'(b_ovf), 64'd1);
    start_tile(1, 8);
    chk("ovf_cleared", 64'(b_ovf), 64'd0);

    // Reset during collection
    reset_all();
    rdy = 1'b1;
    start_tile(0, 3);
    strobe(0, 5);
    strobe(0, 5);
    mon_en = 1'b0;
    shift = 1'b1;
    rst = 1'b1;
    tick();
    shift = 1'b0;
    rst = 1'b0;
    chk("mrst_outs", 64'({a_vld, a_busy, a_done, a_ovf}), 64'd0);
    chk("mrst_data", a_data, 64'd0);
    for (int s = 0; s < 6; s++) begin
      shift = 1'b1;
      tick();
      shift = 1'b0;
      chk("mrst_shift_ignored", 64'({a_vld, a_busy}), 64'd0);
    end
    start_tile(0, 3);
    for (int s = 0; s < 6; s++) strobe(0, 5);
    wait_done("mrst_next");
    for (int r = 0; r < 3; r++) chk("mrst_tbl", m_got[r], tbl[r].data);

    // START while draining is ignored
    rdy = 1'b0;
    start_tile(0, 3);
    for (int s = 0; s < 6; s++) strobe(0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("race_start_busy", 64'(a_busy), 64'd1);
    chk("race_start_row", 64'(a_row), 64'd0);
    rdy = 1'b1;
    wait_done("race_start");

    // Back-to-back strobes: pops coincide with completions
    start_tile(0, 3);
    for (int s = 0; s < 6; s++) strobe(0, 1);
    wait_done("race_pop");
    for (int r = 0; r < 3; r++) chk("race_pop_tbl", m_got[r], tbl[r].data);

    // Randomized tiles against the scoreboard
    for (int t = 0; t < 24; t++) begin
      reset_all();
      rnd_rdy = 1'b1;
      start_tile(t[0], t[0] ? 8 : 3);
      for (int s = 0; s < (t[0] ? 11 : 6); s++) strobe(1, $urandom_range(1, 6));
      wait_done("rand");
      rnd_rdy = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
